csr_unit: RTL and testbench

Control/status register file and exception controller at the far end of the writeback CSR bus. It consumes the bus produced by the writeback stage and commits CSR writes, exception entry and exception return. It exposes a combinational read port to the execute stage, and drives the pipeline flush (`ex_en`) together with the redirect targets. It also generates the pending-interrupt indication sampled by decode.

---
 rtl/csr_unit.sv | 274 +++++++++++++++++++++++++++
 tb/tb_csr_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// CSR file and exception controller at the end of the writeback CSR bus.
// Timer CSRs (TID/TCFG/TVAL/TICLR) exist only when CSR_TIMER_EN is defined.
module csr_unit #(
    parameter int TIMER_W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [152:0] Wcsr_BUS,
    input  logic         ertn_flush,
    input  logic [7:0]   hw_int,
    input  logic [13:0]  csr_raddr,
    output logic [31:0]  csr_rdata,
    output logic         ex_en,
    output logic [31:0]  ex_entry,
    output logic         ertn_en,
    output logic [31:0]  ertn_pc,
    output logic         has_int
);

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
`ifdef CSR_TIMER_EN
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;
`endif

    logic               bus_ex;
    logic [7:0]         bus_ecode;
    logic               bus_esub;
    logic               bus_we;
    logic [13:0]        bus_addr;
    logic [TIMER_W-1:0] bus_wmask;
    logic [TIMER_W-1:0] bus_wdata;
    logic [31:0]        bus_pc;
    logic [31:0]        bus_vaddr;

    assign {bus_ex, bus_ecode, bus_esub, bus_we, bus_addr,
            bus_wmask, bus_wdata, bus_pc, bus_vaddr} = Wcsr_BUS;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [31:0] wm
    );
        return (wd & wm) | (old & ~wm);
    endfunction

    logic [8:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] ecfg;
    logic [1:0]  is_sw;
    logic [7:0]  is_hw;
    logic        is_tm;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry;
    logic [31:0] save [4];

    logic [12:0] is_all;
    logic [31:0] estat_rd;

    // An exception cancels any CSR write retiring alongside it.
    logic wr;
    logic we_crmd, we_prmd, we_ecfg, we_estat;
    logic we_era, we_badv, we_eentry;
    logic [3:0] we_save;
    logic badv_hit;

    assign wr        = bus_we && !bus_ex;
    assign we_crmd   = wr && (bus_addr == A_CRMD);
    assign we_prmd   = wr && (bus_addr == A_PRMD);
    assign we_ecfg   = wr && (bus_addr == A_ECFG);
    assign we_estat  = wr && (bus_addr == A_ESTAT);
    assign we_era    = wr && (bus_addr == A_ERA);
    assign we_badv   = wr && (bus_addr == A_BADV);
    assign we_eentry = wr && (bus_addr == A_EENTRY);
    assign we_save[0] = wr && (bus_addr == A_SAVE0);
    assign we_save[1] = wr && (bus_addr == A_SAVE1);
    assign we_save[2] = wr && (bus_addr == A_SAVE2);
    assign we_save[3] = wr && (bus_addr == A_SAVE3);
    assign badv_hit  = (bus_ecode == 8'h08) || (bus_ecode == 8'h09);

    assign ex_en    = bus_ex;
    assign ex_entry = {eentry, 6'b0};
    assign ertn_en  = ertn_flush && !bus_ex;
    assign ertn_pc  = era;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crmd <= 9'h008;
        end else if (bus_ex) begin
            crmd[2:0] <= 3'b000;
        end else if (ertn_en) begin
            crmd[2:0] <= prmd;
        end else if (we_crmd) begin
            crmd <= 9'(merge({23'b0, crmd}, bus_wdata, bus_wmask));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prmd <= 3'b000;
        end else if (bus_ex) begin
            prmd <= crmd[2:0];
        end else if (we_prmd) begin
            prmd <= 3'(merge({29'b0, prmd}, bus_wdata, bus_wmask));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ecfg <= '0;
        end else if (we_ecfg) begin
            ecfg <= 13'(merge({19'b0, ecfg}, bus_wdata, bus_wmask))
                    & 13'h1BFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            is_hw <= '0;
            is_sw <= '0;
            ecode <= '0;
            esub  <= '0;
        end else begin
            is_hw <= hw_int;
            if (we_estat) begin
                is_sw <= 2'(merge({30'b0, is_sw}, bus_wdata, bus_wmask));
            end
            if (bus_ex) begin
                ecode <= bus_ecode[5:0];
                esub  <= {8'b0, bus_esub};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            era    <= '0;
            badv   <= '0;
            eentry <= '0;
        end else begin
            if (bus_ex) begin
                era <= bus_pc;
            end else if (we_era) begin
                era <= merge(era, bus_wdata, bus_wmask);
            end
            if (bus_ex) begin
                if (badv_hit) begin
                    badv <= bus_vaddr;
                end
            end else if (we_badv) begin
                badv <= merge(badv, bus_wdata, bus_wmask);
            end
            if (we_eentry) begin
                eentry <= 26'(merge({eentry, 6'b0}, bus_wdata, bus_wmask)
                              >> 6);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                save[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we_save[i]) begin
                    save[i] <= merge(save[i], bus_wdata, bus_wmask);
                end
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic [TIMER_W-1:0] tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;
    logic [TIMER_W-1:0] tcfg_new;
    logic               we_tid, we_tcfg, we_ticlr;
    logic               timer_set, timer_clr;

    assign we_tid    = wr && (bus_addr == A_TID);
    assign we_tcfg   = wr && (bus_addr == A_TCFG);
    assign we_ticlr  = wr && (bus_addr == A_TICLR);
    assign tcfg_new  = merge(tcfg, bus_wdata, bus_wmask);
    // A TCFG write reloads TVAL, so no 1->0 expiry happens that cycle.
    assign timer_set = tcfg[0] && (tval == 1) && !we_tcfg;
    assign timer_clr = we_ticlr && bus_wdata[0] && bus_wmask[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tid  <= '0;
            tcfg <= '0;
        end else begin
            if (we_tid) begin
                tid <= merge(tid, bus_wdata, bus_wmask);
            end
            if (we_tcfg) begin
                tcfg <= tcfg_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tval <= '0;
        end else if (we_tcfg) begin
            tval <= {tcfg_new[TIMER_W-1:2], 2'b00};
        end else if (tcfg[0]) begin
            if (tval != 0) begin
                tval <= tval - 1'b1;
            end else if (tcfg[1]) begin
                tval <= {tcfg[TIMER_W-1:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            is_tm <= 1'b0;
        end else if (timer_set) begin
            is_tm <= 1'b1;
        end else if (timer_clr) begin
            is_tm <= 1'b0;
        end
    end
`else
    assign is_tm = 1'b0;
`endif

    assign is_all   = {1'b0, is_tm, 1'b0, is_hw, is_sw};
    assign estat_rd = {1'b0, esub, ecode, 3'b000, is_all};
    assign has_int  = crmd[2] && |(is_all & ecfg);

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            A_CRMD:   csr_rdata = {23'b0, crmd};
            A_PRMD:   csr_rdata = {29'b0, prmd};
            A_ECFG:   csr_rdata = {19'b0, ecfg};
            A_ESTAT:  csr_rdata = estat_rd;
            A_ERA:    csr_rdata = era;
            A_BADV:   csr_rdata = badv;
            A_EENTRY: csr_rdata = {eentry, 6'b0};
            A_SAVE0:  csr_rdata = save[0];
            A_SAVE1:  csr_rdata = save[1];
            A_SAVE2:  csr_rdata = save[2];
            A_SAVE3:  csr_rdata = save[3];
`ifdef CSR_TIMER_EN
            A_TID:    csr_rdata = tid;
            A_TCFG:   csr_rdata = tcfg;
            A_TVAL:   csr_rdata = tval;
            A_TICLR:  csr_rdata = '0;
`endif
            default:  csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed steps then random bus traffic
// compared every cycle against a field-level reference model.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        b_ex;
    logic [7:0]  b_ecode;
    logic        b_esub;
    logic        b_we;
    logic [13:0] b_addr;
    logic [31:0] b_wmask;
    logic [31:0] b_wdata;
    logic [31:0] b_pc;
    logic [31:0] b_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        ex_en;
    logic [31:0] ex_entry;
    logic        ertn_en;
    logic [31:0] ertn_pc;
    logic        has_int;
    logic [152:0] bus;

    assign bus = {b_ex, b_ecode, b_esub, b_we, b_addr,
                  b_wmask, b_wdata, b_pc, b_vaddr};

    always #5 clk = ~clk;

    csr_unit #(.TIMER_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Wcsr_BUS   (bus),
        .ertn_flush (ertn_flush),
        .hw_int     (hw_int),
        .csr_raddr  (csr_raddr),
        .csr_rdata  (csr_rdata),
        .ex_en      (ex_en),
        .ex_entry   (ex_entry),
        .ertn_en    (ertn_en),
        .ertn_pc    (ertn_pc),
        .has_int    (has_int)
    );

    localparam int A_CRMD = 'h00, A_PRMD = 'h01, A_ECFG = 'h04;
    localparam int A_ESTAT = 'h05, A_ERA = 'h06, A_BADV = 'h07;
    localparam int A_EENTRY = 'h0C, A_TID = 'h40, A_TCFG = 'h41;
    localparam int A_TVAL = 'h42, A_TICLR = 'h44;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural register values by address,
    // with ESTAT kept as its named fields.
    int unsigned r[int];
    int unsigned tval;
    bit [1:0]    is_sw;
    bit [7:0]    is_hw;
    bit          is_tm;
    bit [5:0]    m_ecode;
    bit [8:0]    m_esub;

    function automatic int unsigned wr_mask(int a);
        if (a == A_CRMD) return 32'h1FF;
        if (a == A_PRMD) return 32'h7;
        if (a == A_ECFG) return 32'h1BFF;
        if (a == A_ERA || a == A_BADV) return 32'hFFFF_FFFF;
        if (a == A_EENTRY) return 32'hFFFF_FFC0;
        if (a >= 'h30 && a <= 'h33) return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
        if (a == A_TID || a == A_TCFG) return 32'hFFFF_FFFF;
`endif
        return 0;
    endfunction

    function automatic int unsigned mread(int a);
        if (a == A_ESTAT)
            return {1'b0, m_esub, m_ecode, 3'b0,
                    1'b0, is_tm, 1'b0, is_hw, is_sw};
`ifdef CSR_TIMER_EN
        if (a == A_TVAL) return tval;
`endif
        if (r.exists(a)) return r[a];
        return 0;
    endfunction

    function automatic bit m_has_int();
        int unsigned pend;
        pend = mread(A_ESTAT) & r[A_ECFG] & 32'h1FFF;
        return ((r[A_CRMD] & 32'h4) != 0) && (pend != 0);
    endfunction

    task automatic model_reset();
        r.delete();
        r[A_CRMD] = 8;
        r[A_PRMD] = 0;
        r[A_ECFG] = 0;
        r[A_ERA] = 0;
        r[A_BADV] = 0;
        r[A_EENTRY] = 0;
        for (int i = 'h30; i <= 'h33; i++) r[i] = 0;
`ifdef CSR_TIMER_EN
        r[A_TID] = 0;
        r[A_TCFG] = 0;
`endif
        tval = 0;
        is_sw = 0;
        is_hw = 0;
        is_tm = 0;
        m_ecode = 0;
        m_esub = 0;
    endtask

    task automatic model_step();
        int unsigned nr[int];
        int unsigned ntval;
        int unsigned nv;
        int a;
        bit tset;
        bit tclr;
        bit [1:0] nsw;
        if (!rstn) begin
            model_reset();
            return;
        end
        nr = r;
        ntval = tval;
        tset = 0;
        tclr = 0;
        nsw = is_sw;
        a = int'(b_addr);
`ifdef CSR_TIMER_EN
        if ((r[A_TCFG] & 1) != 0) begin
            if (tval != 0) begin
                ntval = tval - 1;
                tset = (tval == 1);
            end else if ((r[A_TCFG] & 2) != 0) begin
                ntval = r[A_TCFG] & ~32'h3;
            end
        end
`endif
        if (b_ex) begin
            nr[A_PRMD] = r[A_CRMD] & 7;
            nr[A_CRMD] = r[A_CRMD] & ~32'h7;
            nr[A_ERA] = b_pc;
            if (b_ecode == 8 || b_ecode == 9) nr[A_BADV] = b_vaddr;
            m_ecode = b_ecode[5:0];
            m_esub = {8'b0, b_esub};
        end else begin
            if (ertn_flush)
                nr[A_CRMD] = (r[A_CRMD] & ~32'h7) | (r[A_PRMD] & 7);
            if (b_we) begin
                nv = (b_wdata & b_wmask) | (mread(a) & ~b_wmask);
                if (a == A_ESTAT) begin
                    nsw = 2'(nv);
`ifdef CSR_TIMER_EN
                end else if (a == A_TICLR) begin
                    tclr = ((b_wdata & b_wmask & 1) != 0);
`endif
                end else if (wr_mask(a) != 0) begin
                    nr[a] = nv & wr_mask(a);
                    if (a == A_TCFG) begin
                        ntval = nr[a] & ~32'h3;
                        tset = 0;
                    end
                end
            end
        end
        is_hw = hw_int;
        is_sw = nsw;
        tval = ntval;
        if (tset) is_tm = 1;
        else if (tclr) is_tm = 0;
        r = nr;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ex_en", 32'(ex_en), 32'(b_ex));
        chk("ex_entry", ex_entry, r[A_EENTRY]);
        chk("ertn_en", 32'(ertn_en), 32'(ertn_flush && !b_ex));
        chk("ertn_pc", ertn_pc, r[A_ERA]);
        chk("has_int", 32'(has_int), 32'(m_has_int()));
        chk("rdata", csr_rdata, mread(int'(csr_raddr)));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        b_ex = 0;
        b_ecode = 0;
        b_esub = 0;
        b_we = 0;
        b_addr = 0;
        b_wmask = 0;
        b_wdata = 0;
        b_pc = 0;
        b_vaddr = 0;
        ertn_flush = 0;
    endtask

    task automatic wr(int a, logic [31:0] d,
                      logic [31:0] m = 32'hFFFF_FFFF);
        idle();
        b_we = 1;
        b_addr = 14'(a);
        b_wdata = d;
        b_wmask = m;
        tick();
    endtask

    task automatic rd(int a, logic [31:0] exp, string tag);
        idle();
        csr_raddr = 14'(a);
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    int addrs[] = '{'h00, 'h01, 'h04, 'h05, 'h06, 'h07, 'h0C,
                    'h30, 'h31, 'h32, 'h33, 'h40, 'h41, 'h42,
                    'h44, 'h02, 'h08, 'h100, 'h3FFF};

    function automatic int pick_addr();
        return addrs[$urandom_range(0, addrs.size() - 1)];
    endfunction

    initial begin
        model_reset();
        rstn = 0;
        idle();
        hw_int = 0;
        csr_raddr = 0;
        repeat (3) tick();
        rstn = 1;
        rd(A_CRMD, 32'h8, "rst_crmd");
        rd(A_ESTAT, 32'h0, "rst_estat");
        chk("rst_has_int", 32'(has_int), 32'h0);
        chk("rst_ertn_pc", ertn_pc, 32'h0);

        wr('h30, 32'h1234_5678);
        wr('h30, 32'hDEAD_BEEF, 32'hFFFF_0000);
        rd('h30, 32'hDEAD_5678, "save_merge");
        wr(A_CRMD, 32'h7);
        rd(A_CRMD, 32'h7, "crmd_wr");
        wr(A_EENTRY, 32'h1C00_8013);
        rd(A_EENTRY, 32'h1C00_8000, "eentry_mask");

        idle();
        b_ex = 1;
        b_ecode = 8'h09;
        b_pc = 32'h1C00_0100;
        b_vaddr = 32'h3;
        #1;
        chk("ex_same_cycle", 32'(ex_en), 32'h1);
        chk("ex_entry_same", ex_entry, 32'h1C00_8000);
        tick();
        rd(A_CRMD, 32'h0, "ex_crmd");
        rd(A_PRMD, 32'h7, "ex_prmd");
        rd(A_ERA, 32'h1C00_0100, "ex_era");
        rd(A_BADV, 32'h3, "ex_badv");
        rd(A_ESTAT, 32'h0009_0000, "ex_estat");

        idle();
        ertn_flush = 1;
        #1;
        chk("ertn_pc", ertn_pc, 32'h1C00_0100);
        chk("ertn_en_on", 32'(ertn_en), 32'h1);
        tick();
        rd(A_CRMD, 32'h7, "ertn_crmd");

        idle();
        b_ex = 1;
        b_ecode = 8'h03;
        b_pc = 32'h1C00_0200;
        b_vaddr = 32'h55;
        ertn_flush = 1;
        #1;
        chk("ex_ertn_en", 32'(ertn_en), 32'h0);
        tick();
        rd(A_CRMD, 32'h0, "ex_ertn_crmd");
        rd(A_BADV, 32'h3, "ex_badv_hold");
        rd(A_ERA, 32'h1C00_0200, "ex_ertn_era");

        idle();
        b_ex = 1;
        b_we = 1;
        b_addr = 14'h31;
        b_wdata = 32'hA5A5_A5A5;
        b_wmask = 32'hFFFF_FFFF;
        tick();
        rd('h31, 32'h0, "ex_drops_we");
        wr('h100, 32'hFFFF_FFFF);
        rd('h100, 32'h0, "unimpl");

        wr(A_ECFG, 32'h4);
        wr(A_CRMD, 32'h4);
        idle();
        hw_int = 8'h01;
        #1;
        chk("hw_int_pre", 32'(has_int), 32'h0);
        tick();
        chk("hw_int_rise", 32'(has_int), 32'h1);
        hw_int = 8'h00;
        tick();
        tick();
        chk("hw_int_fall", 32'(has_int), 32'h0);

`ifdef CSR_TIMER_EN
        wr(A_ECFG, 32'h800);
        wr(A_TCFG, 32'h0000_000B);
        rd(A_TVAL, 32'h8, "tval_load");
        for (int k = 1; k <= 8; k++) begin
            tick();
            rd(A_TVAL, 32'(8 - k), "tval_count");
        end
        chk("timer_int", 32'(has_int), 32'h1);
        tick();
        rd(A_TVAL, 32'h8, "tval_reload");
        wr(A_TICLR, 32'h1);
        chk("ticlr_clears", 32'(has_int), 32'h0);
        wr(A_TCFG, 32'h0);
`else
        wr(A_TCFG, 32'h0000_000B);
        rd(A_TCFG, 32'h0, "no_tcfg");
        rd(A_TVAL, 32'h0, "no_tval");
`endif

        for (int i = 0; i < 600; i++) begin
            int sel;
            idle();
            rstn = !(i >= 300 && i < 302);
            if ($urandom_range(0, 3) == 0) hw_int = 8'($urandom);
            csr_raddr = 14'(pick_addr());
            b_pc = $urandom;
            b_vaddr = $urandom;
            b_esub = 1'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 5 || sel == 7) begin
                b_we = 1;
                b_addr = 14'(pick_addr());
                b_wdata = $urandom;
                case ($urandom_range(0, 2))
                    0: b_wmask = 32'hFFFF_FFFF;
                    1: b_wmask = $urandom;
                    default: b_wmask = 32'h0;
                endcase
                if (b_addr == 14'(A_TCFG)) begin
                    b_wdata = 32'($urandom_range(0, 63));
                    b_wmask = 32'hFFFF_FFFF;
                end
            end
            if (sel == 5 || sel == 7 || sel == 8) begin
                b_ex = 1;
                case ($urandom_range(0, 2))
                    0: b_ecode = 8'h08;
                    1: b_ecode = 8'h09;
                    default: b_ecode = 8'($urandom);
                endcase
            end
            if (sel == 6 || sel == 8) ertn_flush = 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
